// File: rtl/spoofer_avst_pkt.sv
// Avalon-ST packet pattern source: sop/eop framed packets on round-robin channels,
// selectable data pattern, programmable inter-packet gap and optional packet limit.
module spoofer_avst_pkt #(
   parameter int DATA_WIDTH = 32,
   parameter int CHANNELS   = 4,
   parameter int PKT_LEN    = 16,
   parameter int GAP        = 2,
   parameter int NUM_PKTS   = 0,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic                  ready,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic [CH_W-1:0]       channel,
   output logic                  sop,
   output logic                  eop,
   output logic                  done,
   output logic [15:0]           pkt_count,
   output logic [1:0]            dbg_state
);

   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [BW-1:0]   LAST_BEAT = BW'(PKT_LEN - 1);
   localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [CH_W-1:0] CH_LAST   = CH_W'(CHANNELS - 1);
   localparam logic [15:0]     PKT_LIMIT = 16'(NUM_PKTS);
   localparam logic            ONE_BEAT  = (PKT_LEN == 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]            state, state_n;
   logic [BW-1:0]         beat, beat_n;
   logic [GW-1:0]         gap_cnt, gap_n;
   logic [DATA_WIDTH-1:0] word_cnt, cnt_n;
   logic [DATA_WIDTH-1:0] walk, walk_n;
   logic [1:0]            mode_q, mode_n;
   logic                  valid_n, sop_n, eop_n, done_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic [CH_W-1:0]       channel_n;
   logic [15:0]           pkt_n;
   logic                  xfer, start_ok, launch;
   logic [15:0]           pkt_inc;
   logic [CH_W-1:0]       ch_next;

   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                     input logic [DATA_WIDTH-1:0] c,
                                                     input logic [DATA_WIDTH-1:0] w);
      case (m)
         2'd1:    return w;
         2'd2:    return ~c;
         default: return c;
      endcase
   endfunction

   // Handshake: a beat transfers on every clk edge with valid && ready; once valid
   // is raised, data/channel/sop/eop hold and valid stays high until that transfer.
   assign xfer     = valid && ready;
   assign start_ok = enable && !done;
   assign pkt_inc  = pkt_count + 16'd1;
   assign ch_next  = (channel == CH_LAST) ? '0 : channel + CH_W'(1);
   assign dbg_state = state;

   always_comb begin
      state_n   = state;
      beat_n    = beat;
      gap_n     = gap_cnt;
      cnt_n     = word_cnt;
      walk_n    = walk;
      mode_n    = mode_q;
      valid_n   = valid;
      sop_n     = sop;
      eop_n     = eop;
      data_n    = data;
      channel_n = channel;
      done_n    = done;
      pkt_n     = pkt_count;
      launch    = 1'b0;
      case (state)
         S_IDLE: launch = start_ok;
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               if (start_ok) launch = 1'b1;
               else          state_n = S_IDLE;
            end else begin
               gap_n = gap_cnt + GW'(1);
            end
         end
         S_SEND: begin
            if (xfer) begin
               // pattern sources advance on every transfer, whatever the mode
               cnt_n  = word_cnt + DATA_WIDTH'(1);
               walk_n = {walk[DATA_WIDTH-2:0], walk[DATA_WIDTH-1]};
               if (eop) begin
                  pkt_n     = pkt_inc;
                  channel_n = ch_next;
                  valid_n   = 1'b0;
                  sop_n     = 1'b0;
                  eop_n     = 1'b0;
                  if ((NUM_PKTS != 0) && (pkt_inc == PKT_LIMIT)) begin
                     done_n  = 1'b1;
                     state_n = S_DONE;
                  end else if (GAP > 0) begin
                     gap_n   = '0;
                     state_n = S_GAP;
                  end else if (start_ok) begin
                     launch = 1'b1;
                  end else begin
                     state_n = S_IDLE;
                  end
               end else begin
                  beat_n = beat + BW'(1);
                  sop_n  = 1'b0;
                  eop_n  = (beat_n == LAST_BEAT);
                  data_n = pattern(mode_q, cnt_n, walk_n);
               end
            end
         end
         default: ;
      endcase
      // mode is captured only here, so mid-packet changes wait for the next sop
      if (launch) begin
         state_n = S_SEND;
         valid_n = 1'b1;
         sop_n   = 1'b1;
         eop_n   = ONE_BEAT;
         beat_n  = '0;
         mode_n  = mode;
         data_n  = pattern(mode, cnt_n, walk_n);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         beat      <= '0;
         gap_cnt   <= '0;
         word_cnt  <= '0;
         walk      <= DATA_WIDTH'(1);
         mode_q    <= 2'd0;
         valid     <= 1'b0;
         sop       <= 1'b0;
         eop       <= 1'b0;
         data      <= '0;
         channel   <= '0;
         done      <= 1'b0;
         pkt_count <= '0;
      end else begin
         state     <= state_n;
         beat      <= beat_n;
         gap_cnt   <= gap_n;
         word_cnt  <= cnt_n;
         walk      <= walk_n;
         mode_q    <= mode_n;
         valid     <= valid_n;
         sop       <= sop_n;
         eop       <= eop_n;
         data      <= data_n;
         channel   <= channel_n;
         done      <= done_n;
         pkt_count <= pkt_n;
      end
   end

endmodule

// File: tb/tb_spoofer_avst_pkt.sv
// Bench for spoofer_avst_pkt: three parameterisations share stimulus; beats are
// checked against a transfer-index model of the packet stream.
module tb_spoofer_avst_pkt;

   logic clk = 1'b0;
   logic rst, enable, ready;
   logic [1:0] mode;

   always #5 clk = ~clk;

   logic        a_valid, a_sop, a_eop, a_done;
   logic [31:0] a_data;
   logic [1:0]  a_channel, a_dbg_state;
   logic [15:0] a_pkt_count;

   logic        b_valid, b_sop, b_eop, b_done;
   logic [7:0]  b_data;
   logic [1:0]  b_channel, b_dbg_state;
   logic [15:0] b_pkt_count;

   logic        c_valid, c_sop, c_eop, c_done;
   logic [15:0] c_data;
   logic [0:0]  c_channel;
   logic [1:0]  c_dbg_state;
   logic [15:0] c_pkt_count;

   spoofer_avst_pkt u_a (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ready(ready),
      .valid(a_valid), .data(a_data), .channel(a_channel), .sop(a_sop), .eop(a_eop),
      .done(a_done), .pkt_count(a_pkt_count), .dbg_state(a_dbg_state));

   spoofer_avst_pkt #(.DATA_WIDTH(8), .CHANNELS(3), .PKT_LEN(10), .GAP(0), .NUM_PKTS(3)) u_b (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ready(ready),
      .valid(b_valid), .data(b_data), .channel(b_channel), .sop(b_sop), .eop(b_eop),
      .done(b_done), .pkt_count(b_pkt_count), .dbg_state(b_dbg_state));

   spoofer_avst_pkt #(.DATA_WIDTH(16), .CHANNELS(1), .PKT_LEN(1), .GAP(0), .NUM_PKTS(0)) u_c (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ready(ready),
      .valid(c_valid), .data(c_data), .channel(c_channel), .sop(c_sop), .eop(c_eop),
      .done(c_done), .pkt_count(c_pkt_count), .dbg_state(c_dbg_state));

   logic [47:0] a_beat, b_beat, c_beat;
   assign a_beat = {6'b0, a_sop, a_eop, 8'(a_channel), a_data};
   assign b_beat = {6'b0, b_sop, b_eop, 8'(b_channel), 24'b0, b_data};
   assign c_beat = {6'b0, c_sop, c_eop, 8'(c_channel), 16'b0, c_data};

   int vectors = 0;
   int miscompares = 0;
   logic [47:0] exp_q[$];

   // Transfer n since reset: counter n, walking one at bit n%dw, packet n/plen.
   function automatic logic [47:0] model_beat(input int n, input int m, input int dw,
                                              input int plen, input int chans);
      logic [31:0] mask, cnt, walk, d;
      int pkt;
      mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 32'h1);
      cnt  = 32'(n) & mask;
      walk = 32'h1 << (n % dw);
      case (m)
         1:       d = walk;
         2:       d = ~cnt & mask;
         default: d = cnt;
      endcase
      pkt = n / plen;
      return {6'b0, (n % plen) == 0, (n % plen) == (plen - 1), 8'(pkt % chans), d};
   endfunction

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; ready = 1'b1; mode = 2'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; ready = 1'b1; mode = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (a_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", a_valid); miscompares++; end
      vectors++; if (a_sop !== 1'b0 || a_eop !== 1'b0) begin $display("FAIL reset_sop_eop: got %b%b expected 00", a_sop, a_eop); miscompares++; end
      vectors++; if (a_data !== 32'h0) begin $display("FAIL reset_data: got %h expected 0", a_data); miscompares++; end
      vectors++; if (a_channel !== 2'd0) begin $display("FAIL reset_channel: got %0d expected 0", a_channel); miscompares++; end
      vectors++; if (a_done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", a_done); miscompares++; end
      vectors++; if (a_pkt_count !== 16'd0) begin $display("FAIL reset_pkt_count: got %0d expected 0", a_pkt_count); miscompares++; end
      vectors++; if (b_valid !== 1'b0 || c_valid !== 1'b0) begin $display("FAIL reset_valid_bc: got %b%b expected 00", b_valid, c_valid); miscompares++; end
      #1 enable = 1'b0; rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++; if (a_valid !== 1'b0) begin $display("FAIL idle_no_enable: got %b expected 0", a_valid); miscompares++; end
      end
   endtask

   task automatic test_stream();
      int n, idle, cyc;
      logic [47:0] exp_v;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 96; i++) exp_q.push_back(model_beat(i, 0, 32, 16, 4));
      enable = 1'b1;
      n = 0; idle = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 400) begin
         @(posedge clk); #1;
         @(negedge clk); cyc++;
         if (a_valid && ready) begin
            exp_v = exp_q.pop_front();
            vectors++; if (a_beat !== exp_v) begin $display("FAIL stream_beat[%0d]: got %h expected %h", n, a_beat, exp_v); miscompares++; end
            if (a_sop && n > 0) begin
               vectors++; if (idle != 2) begin $display("FAIL stream_gap[%0d]: got %0d idle cycles expected 2", n, idle); miscompares++; end
            end
            idle = 0; n++;
         end else if (n > 0) begin
            idle++;
         end
      end
      vectors++; if (exp_q.size() != 0) begin $display("FAIL stream_timeout: got %0d beats expected 96", n); miscompares++; end
      @(posedge clk); #1 ready = 1'b0;
      @(negedge clk);
      vectors++; if (a_pkt_count !== 16'd6) begin $display("FAIL stream_pkt_count: got %0d expected 6", a_pkt_count); miscompares++; end
      vectors++; if (a_done !== 1'b0) begin $display("FAIL stream_done: got %b expected 0", a_done); miscompares++; end
   endtask

   task automatic test_backpressure();
      int n, cyc, m;
      logic have_prev;
      logic [47:0] prev, exp_v;
      do_reset();
      m = $urandom_range(0, 3);
      exp_q.delete();
      for (int i = 0; i < 48; i++) exp_q.push_back(model_beat(i, m, 32, 16, 4));
      mode = 2'(m); enable = 1'b1;
      n = 0; cyc = 0; have_prev = 1'b0; prev = '0;
      while (exp_q.size() > 0 && cyc < 1000) begin
         @(posedge clk); #1 ready = ($urandom_range(0, 1) == 1);
         @(negedge clk); cyc++;
         if (have_prev) begin
            vectors++;
            if (a_valid !== 1'b1 || a_beat !== prev) begin
               $display("FAIL bp_hold[%0d]: got valid=%b beat=%h expected valid=1 beat=%h", n, a_valid, a_beat, prev);
               miscompares++;
            end
         end
         have_prev = a_valid && !ready;
         prev = a_beat;
         if (a_valid && ready) begin
            exp_v = exp_q.pop_front();
            vectors++; if (a_beat !== exp_v) begin $display("FAIL bp_beat[%0d] mode %0d: got %h expected %h", n, m, a_beat, exp_v); miscompares++; end
            n++;
         end
      end
      vectors++; if (exp_q.size() != 0) begin $display("FAIL bp_timeout: got %0d beats expected 48", n); miscompares++; end
      @(posedge clk); #1 ready = 1'b0;
      @(negedge clk);
      vectors++; if (a_pkt_count !== 16'd3) begin $display("FAIL bp_pkt_count: got %0d expected 3", a_pkt_count); miscompares++; end
   endtask

   task automatic test_enable_drop();
      int n, cyc;
      logic [47:0] exp_v;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 32; i++) exp_q.push_back(model_beat(i, 0, 32, 16, 4));
      enable = 1'b1;
      n = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
         @(posedge clk); #1 if (n >= 22) enable = 1'b0;
         @(negedge clk); cyc++;
         if (a_valid) begin
            exp_v = exp_q.pop_front();
            vectors++; if (a_beat !== exp_v) begin $display("FAIL en_drop_beat[%0d]: got %h expected %h", n, a_beat, exp_v); miscompares++; end
            n++;
         end
      end
      vectors++; if (exp_q.size() != 0) begin $display("FAIL en_drop_timeout: got %0d beats expected 32", n); miscompares++; end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         vectors++; if (a_valid !== 1'b0) begin $display("FAIL en_drop_idle[%0d]: got %b expected 0", i, a_valid); miscompares++; end
      end
   endtask

   task automatic test_reset_mid();
      int n, cyc;
      logic [47:0] exp_v;
      exp_q.delete();
      for (int i = 32; i < 40; i++) exp_q.push_back(model_beat(i, 0, 32, 16, 4));
      enable = 1'b1;
      n = 32; cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
         @(posedge clk); #1;
         @(negedge clk); cyc++;
         if (a_valid) begin
            exp_v = exp_q.pop_front();
            vectors++; if (a_beat !== exp_v) begin $display("FAIL resume_beat[%0d]: got %h expected %h", n, a_beat, exp_v); miscompares++; end
            n++;
         end
      end
      vectors++; if (exp_q.size() != 0) begin $display("FAIL resume_timeout: got %0d expected 40", n); miscompares++; end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      vectors++; if (a_valid !== 1'b0 || a_sop !== 1'b0 || a_eop !== 1'b0) begin $display("FAIL mid_reset_ctrl: got v/s/e %b%b%b expected 000", a_valid, a_sop, a_eop); miscompares++; end
      vectors++; if (a_data !== 32'h0 || a_channel !== 2'd0) begin $display("FAIL mid_reset_data: got %h ch %0d expected 0 ch 0", a_data, a_channel); miscompares++; end
      vectors++; if (a_pkt_count !== 16'd0) begin $display("FAIL mid_reset_pkt_count: got %0d expected 0", a_pkt_count); miscompares++; end
      exp_v = model_beat(0, 0, 32, 16, 4);
      cyc = 0;
      while (!a_valid && cyc < 10) begin
         @(negedge clk); cyc++;
      end
      vectors++; if (a_beat !== exp_v || !a_valid) begin $display("FAIL after_reset_beat: got valid=%b %h expected %h", a_valid, a_beat, exp_v); miscompares++; end
   endtask

   task automatic test_walking_mode();
      int n, cyc;
      logic [47:0] exp_v;
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(model_beat(i, 1, 8, 10, 3));
      mode = 2'd1; enable = 1'b1;
      n = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
         @(posedge clk); #1 if (n >= 4) mode = 2'd2;
         @(negedge clk); cyc++;
         if (b_valid) begin
            exp_v = exp_q.pop_front();
            vectors++; if (b_beat !== exp_v) begin $display("FAIL walk_beat[%0d]: got %h expected %h", n, b_beat, exp_v); miscompares++; end
            n++;
         end
      end
      vectors++; if (exp_q.size() != 0) begin $display("FAIL walk_timeout: got %0d beats expected 10", n); miscompares++; end
   endtask

   task automatic test_num_pkts();
      int n, cyc;
      logic [47:0] exp_v;
      exp_q.delete();
      for (int i = 10; i < 30; i++) exp_q.push_back(model_beat(i, 2, 8, 10, 3));
      n = 10; cyc = 0;
      while (exp_q.size() > 0 && cyc < 40) begin
         @(posedge clk); #1;
         @(negedge clk); cyc++;
         vectors++; if (b_valid !== 1'b1) begin $display("FAIL b2b_valid[%0d]: got %b expected 1", n, b_valid); miscompares++; end
         if (b_valid) begin
            exp_v = exp_q.pop_front();
            vectors++; if (b_beat !== exp_v) begin $display("FAIL b2b_beat[%0d]: got %h expected %h", n, b_beat, exp_v); miscompares++; end
            n++;
         end
      end
      vectors++; if (exp_q.size() != 0) begin $display("FAIL b2b_timeout: got %0d expected 30", n); miscompares++; end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++; if (b_done !== 1'b1) begin $display("FAIL limit_done: got %b expected 1", b_done); miscompares++; end
      vectors++; if (b_pkt_count !== 16'd3) begin $display("FAIL limit_pkt_count: got %0d expected 3", b_pkt_count); miscompares++; end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1 enable = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         vectors++; if (b_valid !== 1'b0 || b_done !== 1'b1) begin $display("FAIL limit_hold[%0d]: got valid=%b done=%b expected 0 1", i, b_valid, b_done); miscompares++; end
      end
   endtask

   task automatic test_single_beat();
      int n, cyc, m;
      logic [47:0] exp_v;
      do_reset();
      m = $urandom_range(0, 3);
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back(model_beat(i, m, 16, 1, 1));
      mode = 2'(m); enable = 1'b1;
      n = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 400) begin
         @(posedge clk); #1 ready = ($urandom_range(0, 1) == 1);
         @(negedge clk); cyc++;
         if (c_valid && ready) begin
            exp_v = exp_q.pop_front();
            vectors++; if (c_beat !== exp_v) begin $display("FAIL single_beat[%0d] mode %0d: got %h expected %h", n, m, c_beat, exp_v); miscompares++; end
            n++;
         end
      end
      vectors++; if (exp_q.size() != 0) begin $display("FAIL single_timeout: got %0d beats expected 20", n); miscompares++; end
      @(posedge clk); #1 ready = 1'b0;
      @(negedge clk);
      vectors++; if (c_pkt_count !== 16'd20) begin $display("FAIL single_pkt_count: got %0d expected 20", c_pkt_count); miscompares++; end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; ready = 1'b1; mode = 2'd0;
      test_reset();
      test_stream();
      test_backpressure();
      test_enable_drop();
      test_reset_mid();
      test_walking_mode();
      test_num_pkts();
      test_single_beat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spoofer_avst_pkt.md
Name: spoofer_avst_pkt

Overview:
Parametrised Avalon-ST test-pattern source and successor to the single-beat spoofer.
- Emits packetised streams with startofpacket/endofpacket framing.
- Rotates round-robin over CHANNELS logical channels.
- Offers selectable data patterns, a programmable inter-packet gap and an optional packet-count limit.
- Used in FPGA testbenches and bring-up to drive any AVST sink under full backpressure.

Parameters:
DATA_WIDTH, 32, width of the data bus (>= 8).
CHANNELS, 4, number of channels, values 1..256.
PKT_LEN, 16, beats per packet, >= 1.
GAP, 2, idle cycles after each packet's eop transfer, >= 0.
NUM_PKTS, 0, packets to send before stopping; 0 = unlimited.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
enable  in  1  permits new packets to start.
mode  in  2  pattern select: 0 counter, 1 walking-one, 2 inverted counter, 3 treated as 0.
ready  in  1  AVST sink ready (readyLatency 0).
valid  out  1  AVST valid.
data  out  DATA_WIDTH  AVST data.
channel  out  CH_W  AVST channel, where CH_W = max(1, $clog2(CHANNELS)).
sop  out  1  startofpacket.
eop  out  1  endofpacket.
done  out  1  NUM_PKTS packets completed; sticky until reset.
pkt_count  out  16  completed packets, wraps at 2^16.

Behaviour:
- Transfer: occurs on any clk edge where valid && ready.
- Stability: while valid=1 and ready=0, data, channel, sop and eop hold stable. valid never drops without a transfer.
- All outputs are registered.

Reset (rst=1 at a clk edge):
- valid=0, sop=0, eop=0, data=0, channel=0, done=0, pkt_count=0.
- Internal state: word counter=0, walking-one register=1 (LSB set), beat index=0, FSM=IDLE.
- Reset mid-packet aborts the packet immediately. No eop is emitted.

FSM states:
- IDLE: valid=0. If enable=1 and done=0: latch mode, load beat 0 with sop=1 (eop=1 too if PKT_LEN=1), assert valid next cycle, go to SEND.
- SEND: on each transfer, beat index increments and the next word is loaded in the same edge. The sop transfer clears sop. eop is asserted on beat PKT_LEN-1. On the eop transfer:
  - pkt_count increments.
  - channel advances: (channel+1) mod CHANNELS.
  - If NUM_PKTS!=0 and the new pkt_count==NUM_PKTS, set done and go to DONE.
  - Else, if GAP>0, go to GAP.
  - Else, if enable=1, restart a packet back-to-back with sop on the next beat and valid staying 1.
  - Else go to IDLE with valid=0.
- GAP: valid=0 for exactly GAP cycles, then behave as IDLE (start only if enable=1).
- DONE: valid=0 and done=1 until rst.

Enable and mode:
- enable deasserted mid-packet does not truncate the packet. The current packet finishes, then the FSM goes to IDLE.
- mode is sampled only at packet start. Changes mid-packet are ignored.

Data per transfer:
- counter: data = word counter. Increments by 1 per transfer in all modes and wraps modulo 2^DATA_WIDTH.
- walking-one: data = walking-one register. Rotates left 1 bit per transfer, MSB wraps to LSB.
- inverted counter: data = ~word counter.
- Counter and walking-one register persist across packets and channels. Only rst clears them.

Boundaries:
- CHANNELS=1: channel constant 0.
- PKT_LEN=1: every beat has sop=eop=1.
- NUM_PKTS=0: done is never set. pkt_count wraps 0xFFFF->0.

Test Plan:
- Defaults, ready=1, enable=1, mode=0 -> 16-beat packets. data 0..15 on channel 0 with sop on data=0 and eop on data=15. 2 idle cycles, then data 16..31 on channel 1 (sop on 16). Channel wraps 3->0 at packet 5.
- Random backpressure (ready 50%) -> every beat's data/sop/eop/channel stable while valid && !ready. No valid drop before transfer. Beat sequence identical to the ready=1 case.
- mode=1, DATA_WIDTH=8, PKT_LEN=10 -> data 0x01,0x02,...,0x80,0x01,0x02. mode changed to 2 mid-packet -> no effect until the next sop.
- NUM_PKTS=3, GAP=0 -> three back-to-back packets, valid continuous across boundaries. done=1 and pkt_count=3 after the third eop. valid=0 thereafter, regardless of enable.
- enable dropped at beat 5 of a packet -> packet completes through eop, then valid=0 until enable returns. rst asserted at beat 7 of a later packet -> next cycle valid=0, data=0, channel=0, pkt_count=0.
- PKT_LEN=1, CHANNELS=1 -> every transfer has sop=eop=1 and channel=0.
